// File: rtl/col_parity_ctrl_if.sv
// ----------------------------------------------------------------------------
// col_parity_ctrl_if
//
// Groups the control/handshake signals between the column-parity controller,
// its datapath (slice counter, line register) and the state/result memories.
//
//   start      sequencer -> ctrl   begin one pass (sampled in IDLE only)
//   mem_ready  memory    -> ctrl   memory accepts an access this cycle
//   cnt_value  datapath  -> ctrl   slice counter value
//   cnt_co     datapath  -> ctrl   slice counter carry-out (monitor only)
//   rd_addr    ctrl -> state mem   read address (combinational read)
//   wr_addr    ctrl -> result mem  write address
//   wr_en      ctrl -> result mem  write strobe
//   inreg_en   ctrl -> datapath    line-register load
//   cnt_en     ctrl -> datapath    counter increment
//   cnt_rst    ctrl -> datapath    counter synchronous clear
//   busy       ctrl -> sequencer   pass in progress
//   done       ctrl -> sequencer   one-cycle completion pulse
//   err        ctrl -> sequencer   sticky carry-out-seen flag
//
// slave  : the controller's view.
// master : the environment's view (sequencer, datapath and memories).
// ----------------------------------------------------------------------------
interface col_parity_ctrl_if #(
    parameter int AW = 6,
    parameter int CW = 7
);
    logic          start;
    logic          mem_ready;
    logic [CW-1:0] cnt_value;
    logic          cnt_co;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic          inreg_en;
    logic          cnt_en;
    logic          cnt_rst;
    logic          busy;
    logic          done;
    logic          err;

    modport slave (
        input  start, mem_ready, cnt_value, cnt_co,
        output rd_addr, wr_addr, wr_en, inreg_en, cnt_en, cnt_rst,
               busy, done, err
    );

    modport master (
        output start, mem_ready, cnt_value, cnt_co,
        input  rd_addr, wr_addr, wr_en, inreg_en, cnt_en, cnt_rst,
               busy, done, err
    );
endinterface

// File: rtl/col_parity_ctrl.sv
// ----------------------------------------------------------------------------
// col_parity_ctrl
//
// Sequences the column-parity datapath over one LINES-deep state memory.
// Each pass first primes the line register with the wrap-around line
// (LINES-1), then streams lines 0..LINES-1; every accepted RUN cycle writes
// colParity(line z-1, line z) to result address z and advances the register.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (returns to IDLE, clears err)
//   bus   col_parity_ctrl_if.slave (see interface header for signal list)
//
// Parameters:
//   LINES  lines per pass, power of two <= 2**AW
//   AW     memory address width, log2(LINES)
//   CW     datapath counter width (must match the datapath counter)
//
// All strobes and addresses are decoded combinationally from the state,
// mem_ready and cnt_value so a mem_ready=0 cycle suppresses every strobe in
// the same cycle; only the state and the sticky err flag are registered.
// ----------------------------------------------------------------------------
module col_parity_ctrl #(
    parameter int LINES = 64,
    parameter int AW    = 6,
    parameter int CW    = 7
) (
    input  logic               clk,
    input  logic               rst,
    col_parity_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        FIN   = 2'd3
    } state_t;

    // Counter value of the final slice; the counter itself finishes at LINES.
    localparam logic [CW-1:0] LAST_CNT   = CW'(LINES - 1);
    // The register is primed with the wrap-around neighbour of line 0.
    localparam logic [AW-1:0] PRIME_ADDR = AW'(LINES - 1);

    state_t state_q;
    logic   err_q;

    // ------------------------------------------------------------------
    // State and sticky error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A new pass starts with a clean error history.
                    if (bus.start) begin
                        state_q <= PRIME;
                        err_q   <= 1'b0;
                    end
                end
                PRIME: begin
                    if (bus.cnt_co) begin
                        err_q <= 1'b1;
                    end
                    if (bus.mem_ready) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // The counter cannot legally wrap within a pass, so a
                    // carry-out here means the datapath is out of step.
                    if (bus.cnt_co) begin
                        err_q <= 1'b1;
                    end
                    if (bus.mem_ready && (bus.cnt_value == LAST_CNT)) begin
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        bus.rd_addr  = '0;
        bus.wr_addr  = '0;
        bus.wr_en    = 1'b0;
        bus.inreg_en = 1'b0;
        bus.cnt_en   = 1'b0;
        bus.cnt_rst  = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;

        case (state_q)
            IDLE: begin
                bus.cnt_rst = 1'b1;
            end
            PRIME: begin
                // Counter held at zero so RUN starts on line 0.
                bus.busy     = 1'b1;
                bus.cnt_rst  = 1'b1;
                bus.rd_addr  = PRIME_ADDR;
                bus.inreg_en = bus.mem_ready;
            end
            RUN: begin
                // Read line z and write result z in the same cycle; the
                // register (line z-1) is replaced by line z at the edge.
                bus.busy     = 1'b1;
                bus.rd_addr  = bus.cnt_value[AW-1:0];
                bus.wr_addr  = bus.cnt_value[AW-1:0];
                bus.wr_en    = bus.mem_ready;
                bus.inreg_en = bus.mem_ready;
                bus.cnt_en   = bus.mem_ready;
            end
            FIN: begin
                // Counter left at LINES for inspection.
                bus.done = 1'b1;
            end
            default: begin
                bus.cnt_rst = 1'b1;
            end
        endcase
    end

    assign bus.err = err_q;

endmodule

// File: tb/tb_col_parity_ctrl.sv
// ----------------------------------------------------------------------------
// tb_col_parity_ctrl
//
// Surrounds the controller with a behavioural datapath (slice counter, line
// register, colParity combiner) and state/result memories, then runs a
// directed sequence of passes with randomized memory stalls. Results are
// compared with a reference computed directly from the memory image:
// result[z] = colParity(line[(z-1) mod 64], line[z]).
// ----------------------------------------------------------------------------
module tb_col_parity_ctrl;

    localparam int LINES = 64;
    localparam int AW    = 6;
    localparam int CW    = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    col_parity_ctrl_if #(.AW(AW), .CW(CW)) bus ();

    col_parity_ctrl #(.LINES(LINES), .AW(AW), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    // ------------------------------------------------------------------
    // Environment: memories and datapath
    // ------------------------------------------------------------------
    logic [24:0] state_mem  [LINES];
    logic [24:0] result_mem [LINES];
    int          result_gen [LINES];
    int          pass_id = 0;
    int          wr_log [4096];
    int          wr_total = 0;
    logic [CW-1:0] cnt_q = '0;
    logic [24:0]   line_reg = '0;
    logic [24:0]   mem_line;

    // Keccak-style theta on a 5x5 slice: bit 5*y+x of a line is lane (x,y).
    function automatic logic [24:0] col_parity(input logic [24:0] prev, input logic [24:0] cur);
        logic [4:0]  c_prev;
        logic [4:0]  c_cur;
        logic [4:0]  d;
        logic [24:0] r;
        for (int x = 0; x < 5; x++) begin
            c_prev[x] = 1'b0;
            c_cur[x]  = 1'b0;
            for (int y = 0; y < 5; y++) begin
                c_prev[x] ^= prev[5*y+x];
                c_cur[x]  ^= cur[5*y+x];
            end
        end
        for (int x = 0; x < 5; x++) begin
            d[x] = c_cur[(x+4)%5] ^ c_prev[(x+1)%5];
        end
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                r[5*y+x] = cur[5*y+x] ^ d[x];
            end
        end
        return r;
    endfunction

    assign mem_line      = state_mem[bus.rd_addr];
    assign bus.cnt_value = cnt_q;

    always @(posedge clk) begin
        if (bus.cnt_rst) begin
            cnt_q <= '0;
        end else if (bus.cnt_en) begin
            cnt_q <= cnt_q + 1'b1;
        end
        if (bus.inreg_en) begin
            line_reg <= mem_line;
        end
        if (bus.wr_en) begin
            result_mem[bus.wr_addr] <= col_parity(line_reg, mem_line);
            result_gen[bus.wr_addr] <= pass_id;
            if (wr_total < 4096) begin
                wr_log[wr_total] <= int'(bus.wr_addr);
            end
            wr_total <= wr_total + 1;
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_nominal();
        for (int z = 0; z < LINES; z++) begin
            state_mem[z] = 25'((z * 32'h10001) & 32'h1FFFFFF);
        end
    endtask

    task automatic fill_random();
        for (int z = 0; z < LINES; z++) begin
            state_mem[z] = 25'($urandom);
        end
    endtask

    // One complete pass starting from IDLE (called at a negedge).
    //   stall_pct   percentage of PRIME/RUN cycles with mem_ready low
    //   hold_start  keep start high throughout (left high on return)
    //   pulse_start random start pulses during RUN
    //   co_pulse    one-cycle cnt_co during RUN
    task automatic run_pass(input string name, input int stall_pct, input bit hold_start,
                            input bit pulse_start, input bit co_pulse);
        int acc;
        int stalls;
        int k;
        int bad_done;
        int bad_strobe;
        int mism;
        int order_bad;
        int base;
        bit co_sent;
        logic [24:0] exp_line;

        pass_id++;
        base       = wr_total;
        acc        = 0;
        stalls     = 0;
        k          = 0;
        bad_done   = 0;
        bad_strobe = 0;
        co_sent    = 1'b0;

        bus.start     = 1'b1;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // 65 accepted cycles are needed: one PRIME plus LINES RUN.
        while (acc < LINES + 1 && k < 1000) begin
            k++;
            if (!hold_start) begin
                bus.start = (pulse_start && acc >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            bus.mem_ready = ($urandom_range(0, 99) >= stall_pct);
            if (co_pulse && !co_sent && acc == 10) begin
                bus.cnt_co = 1'b1;
                co_sent    = 1'b1;
            end
            #1;
            if (k == 1) begin
                check({name, "_prime_busy"},  32'(bus.busy),    32'd1);
                check({name, "_prime_addr"},  32'(bus.rd_addr), 32'(LINES - 1));
                check({name, "_prime_cntrst"},32'(bus.cnt_rst), 32'd1);
                check({name, "_err_cleared"}, 32'(bus.err),     32'd0);
            end
            if (bus.done !== 1'b0) bad_done++;
            if (!bus.mem_ready && (bus.wr_en || bus.inreg_en || bus.cnt_en)) bad_strobe++;
            if (bus.mem_ready) acc++; else stalls++;
            @(negedge clk);
            bus.cnt_co = 1'b0;
        end

        // FIN cycle: cycle number 66 + stalls after start.
        if (!hold_start) bus.start = 1'b0;
        bus.mem_ready = 1'($urandom_range(0, 1));
        #1;
        check({name, "_timeout"},     32'(acc),        32'(LINES + 1));
        check({name, "_done_cycle"},  32'(bus.done),   32'd1);
        check({name, "_fin_busy"},    32'(bus.busy),   32'd0);
        check({name, "_fin_cntrst"},  32'(bus.cnt_rst),32'd0);
        check({name, "_fin_strobes"}, 32'({bus.wr_en, bus.inreg_en, bus.cnt_en}), 32'd0);
        check({name, "_fin_cnt"},     32'(cnt_q),      32'(LINES));
        check({name, "_fin_err"},     32'(bus.err),    32'(co_pulse));
        check({name, "_early_done"},  32'(bad_done),   32'd0);
        check({name, "_stall_strobe"},32'(bad_strobe), 32'd0);
        $display("[TB] %s: done in cycle %0d with %0d stall cycles", name, k + 1, stalls);

        @(negedge clk);
        #1;
        check({name, "_idle_done"}, 32'(bus.done), 32'd0);
        check({name, "_idle_busy"}, 32'(bus.busy), 32'd0);

        mism      = 0;
        order_bad = 0;
        for (int z = 0; z < LINES; z++) begin
            exp_line = col_parity(state_mem[(z + LINES - 1) % LINES], state_mem[z]);
            if (result_gen[z] !== pass_id || result_mem[z] !== exp_line) mism++;
            if (base + z >= 4096 || wr_log[base + z] !== z) order_bad++;
        end
        check({name, "_nwrites"},      32'(wr_total - base), 32'(LINES));
        check({name, "_result"},       32'(mism),            32'd0);
        check({name, "_write_order"},  32'(order_bad),       32'd0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin : stim
        int idle_bad;
        int waited;
        int base;
        bit seen;

        bus.start     = 1'b0;
        bus.mem_ready = 1'b1;
        bus.cnt_co    = 1'b0;
        for (int z = 0; z < LINES; z++) begin
            result_gen[z] = 0;
            result_mem[z] = '0;
        end
        fill_nominal();

        // Reset asserted mid-cycle takes effect without a clock edge.
        #3 rst = 1'b1;
        #1;
        check("rst_cntrst", 32'(bus.cnt_rst), 32'd1);
        check("rst_strobes", 32'({bus.wr_en, bus.inreg_en, bus.cnt_en}), 32'd0);
        check("rst_busy_done", 32'({bus.busy, bus.done}), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_addr", 32'({bus.rd_addr, bus.wr_addr}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        idle_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (bus.wr_en || bus.inreg_en || bus.cnt_en || bus.busy || bus.done || !bus.cnt_rst)
                idle_bad++;
        end
        check("idle_quiet", 32'(idle_bad), 32'd0);
        @(negedge clk);

        run_pass("nominal", 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        run_pass("stall50", 50, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        fill_random();
        run_pass("random_stall30", 30, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        fill_nominal();
        run_pass("start_pulses", 20, 1'b0, 1'b1, 1'b0);
        @(negedge clk);

        // start held high: one pass, then IDLE accepts it again.
        run_pass("start_held", 10, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("held_restart_busy", 32'(bus.busy), 32'd1);
        check("held_restart_addr", 32'(bus.rd_addr), 32'(LINES - 1));
        bus.start     = 1'b0;
        bus.mem_ready = 1'b1;
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
            seen = bus.done;
        end
        check("held_second_done", 32'(seen), 32'd1);
        @(negedge clk);
        @(negedge clk);

        // Reset in the middle of RUN.
        base          = wr_total;
        bus.start     = 1'b1;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        waited    = 0;
        while (cnt_q != 7'd30 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("midrst_reach30", 32'(cnt_q), 32'd30);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_strobes", 32'({bus.wr_en, bus.inreg_en, bus.cnt_en}), 32'd0);
        check("midrst_cntrst", 32'(bus.cnt_rst), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_nwrites", 32'(wr_total - base), 32'd30);
        check("midrst_last_addr", 32'(wr_log[(wr_total > 0) ? wr_total - 1 : 0]), 32'd29);
        @(negedge clk);
        run_pass("after_midrst", 25, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Carry-out monitor: err is sticky until the next accepted start.
        run_pass("co_pulse", 15, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        check("err_sticky_idle", 32'(bus.err), 32'd1);
        @(negedge clk);
        run_pass("err_clear", 0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
